// File: rtl/spi_rx_fifo_if.sv
// Bus bundle between the SPI receiver holding register, the RX FIFO and the core.
// SPI_RX_FIFO_LEVEL_EN adds the fill-level / almost-full signals.
interface spi_rx_fifo_if #(
   parameter int AW = 3
);
   logic          spi_dflag;
   logic [7:0]    spi_dout;
   logic          spi_read;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic          rd_ready;
   logic          full;
   logic          empty;
   logic          stall;
   logic          clear_stall;
`ifdef SPI_RX_FIFO_LEVEL_EN
   logic [AW:0]   level;
   logic [AW:0]   afull_thr;
   logic          afull;

   modport slave (
      input  spi_dflag, spi_dout, rd_ready, clear_stall, afull_thr,
      output spi_read, rd_data, rd_valid, full, empty, stall, level, afull
   );
   modport master (
      output spi_dflag, spi_dout, rd_ready, clear_stall, afull_thr,
      input  spi_read, rd_data, rd_valid, full, empty, stall, level, afull
   );
`else
   modport slave (
      input  spi_dflag, spi_dout, rd_ready, clear_stall,
      output spi_read, rd_data, rd_valid, full, empty, stall
   );
   modport master (
      output spi_dflag, spi_dout, rd_ready, clear_stall,
      input  spi_read, rd_data, rd_valid, full, empty, stall
   );
`endif
endinterface

// File: rtl/spi_rx_fifo.sv
// Pulls bytes out of the SPI receiver holding register into a small FIFO for the core.
// Optional macro SPI_RX_FIFO_LEVEL_EN exposes the fill level and a registered almost-full flag.
module spi_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          reset,
   spi_rx_fifo_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   state_t        state_r;
   state_t        state_next_s;
   logic          spi_read_r;
   logic          stall_r;
   logic          stall_set_s;
   logic [AW-1:0] wptr_r;
   logic [AW-1:0] rptr_r;
   logic [AW:0]   count_r;
   logic [AW:0]   count_next_s;
   logic          full_s;
   logic          empty_s;
   logic          push_s;
   logic          pop_s;
   logic [7:0]    mem_r [DEPTH];

   assign full_s  = (count_r == DEPTH_C);
   assign empty_s = (count_r == {(AW+1){1'b0}});
   // The entry was reserved when IDLE saw !full, so the READ push is never blocked.
   assign push_s  = (state_r == READ);
   assign pop_s   = (!empty_s) && bus.rd_ready;

   // Next-state decode; HOLD ignores spi_dflag while the receiver drops its flag.
   always_comb begin
      state_next_s = state_r;
      stall_set_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.spi_dflag && !full_s) begin
               state_next_s = READ;
            end else if (bus.spi_dflag && full_s) begin
               stall_set_s  = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         READ:    state_next_s = HOLD;
         HOLD:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   always_comb begin
      count_next_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + (AW+1)'(1);
         2'b01:   count_next_s = count_r - (AW+1)'(1);
         default: count_next_s = count_r;
      endcase
   end

   // State register and glitch-free strobe decoded from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         spi_read_r <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         spi_read_r <= (state_next_s == READ);
      end
   end

   // Pointers, occupancy and the sticky stall flag; set beats clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_r  <= {AW{1'b0}};
         rptr_r  <= {AW{1'b0}};
         count_r <= {(AW+1){1'b0}};
         stall_r <= 1'b0;
      end else begin
         if (push_s) begin
            wptr_r <= wptr_r + AW'(1);
         end
         if (pop_s) begin
            rptr_r <= rptr_r + AW'(1);
         end
         count_r <= count_next_s;
         if (stall_set_s) begin
            stall_r <= 1'b1;
         end else if (bus.clear_stall) begin
            stall_r <= 1'b0;
         end
      end
   end

   // Storage has no reset; an in-flight byte is dropped when reset hits during READ.
   always_ff @(posedge clk) begin
      if (!reset && push_s) begin
         mem_r[wptr_r] <= bus.spi_dout;
      end
   end

   assign bus.spi_read = spi_read_r;
   assign bus.rd_data  = mem_r[rptr_r];
   assign bus.rd_valid = !empty_s;
   assign bus.full     = full_s;
   assign bus.empty    = empty_s;
   assign bus.stall    = stall_r;

`ifdef SPI_RX_FIFO_LEVEL_EN
   logic afull_r;

   // Almost-full tracks the count that lands on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         afull_r <= 1'b0;
      end else begin
         afull_r <= (count_next_s >= bus.afull_thr);
      end
   end

   assign bus.level = count_r;
   assign bus.afull = afull_r;
`endif

endmodule

// File: doc/spi_rx_fifo.md
Name: spi_rx_fifo

Overview:
- Downstream consumer of the SPI receiver's parallel holding register.
- Polls the receiver's full flag, issues a one-cycle read strobe, and captures the holding-register byte into a small synchronous FIFO.
- Presents the buffered bytes to the core on a valid/ready interface.
- Decouples the core from SPI frame timing, so bytes are not lost while the core is busy.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
- AW, 3, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; same clock as the SPI receiver's state machine.
- reset  input  1  synchronous, active-high reset.
- spi_dflag  input  1  SPI holding-register full flag.
- spi_dout  input  8  SPI holding-register data.
- spi_read  output  1  read strobe to the SPI receiver; registered, exactly one clk cycle per byte.
- rd_data  output  8  FIFO head byte.
- rd_valid  output  1  FIFO non-empty.
- rd_ready  input  1  core accepts rd_data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- stall  output  1  sticky: spi_dflag was high while the FIFO was full.
- clear_stall  input  1  clears stall.

Behaviour:
- One clock, clk. All state is updated on the rising edge. Reset is synchronous and active-high.
- Reset values:
  - state = IDLE, spi_read = 0, stall = 0.
  - wptr = rptr = 0, count = 0.
  - Therefore empty = 1, full = 0, rd_valid = 0.
  - rd_data = mem[0], contents don't-care.
- Reset mid-operation discards all FIFO contents and any in-flight read. Reset has priority over every other event.
- FSM, 3 states:
  - IDLE:
    - If spi_dflag && !full, go to READ.
    - If spi_dflag && full, stay in IDLE and set stall.
    - Otherwise stay in IDLE.
  - READ:
    - spi_read = 1.
    - mem[wptr] <= spi_dout. The push occurs at the clk edge leaving READ.
    - wptr advances by 1, modulo DEPTH.
    - Go to HOLD unconditionally.
  - HOLD:
    - spi_read = 0.
    - spi_dflag is ignored this cycle while the receiver's flag clears.
    - Go to IDLE.
- spi_read is a registered decode of the next state: it is high exactly while state == READ, with no glitches.
- Latency:
  - spi_dflag sampled high at edge N gives spi_read high in cycle N..N+1.
  - The byte is written at edge N+1.
  - rd_valid is high from edge N+1 if the FIFO was empty.
- Minimum spacing is 3 clk cycles per byte.
- Full is checked only in IDLE. A push in READ is never blocked, because no other push source exists and the entry was reserved when IDLE saw !full.
- Pop:
  - Occurs when rd_valid && rd_ready.
  - rptr advances modulo DEPTH.
  - rd_data is driven combinationally from mem[rptr] and is stable while rd_valid && !rd_ready.
- count (AW+1 bits):
  - Push only: +1.
  - Pop only: -1.
  - Simultaneous push and pop: unchanged, both pointers advance.
  - Pop when empty is impossible because rd_valid = 0.
- Pointer wrap: wptr and rptr wrap from DEPTH-1 to 0. full and empty are derived from count, not from pointer comparison.
- stall:
  - Set in IDLE when spi_dflag && full.
  - Cleared by clear_stall.
  - If set and clear are asserted in the same cycle, set wins.
- No read strobe is issued while full. The byte stays in the SPI holding register until space frees, then is read normally.

Optional Feature:
- Macro: SPI_RX_FIFO_LEVEL_EN.
- When defined:
  - Adds output port level [AW:0], equal to count.
  - Adds input port afull_thr [AW:0] and output afull.
  - afull is registered: afull = (count >= afull_thr), updated on the same edge as count, reset value 0.
- When undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: reset = 1 for 2 cycles → spi_read = 0, empty = 1, full = 0, rd_valid = 0, stall = 0.
- Single byte: spi_dflag = 1, spi_dout = 8'hA5, rd_ready = 0 → spi_read high for exactly 1 cycle. rd_valid = 1 and rd_data = 8'hA5 one edge later. empty = 0.
- Fill and stall: DEPTH = 8, push bytes 8'h01..8'h08 with rd_ready = 0, then hold spi_dflag = 1 → full = 1, no further spi_read, stall = 1. Pulse clear_stall with spi_dflag = 0 → stall = 0.
- Drain with wrap: continue the previous case. Set rd_ready = 1 while pushing 8'h09..8'h0C → pop order 01..0C with no loss or duplication. Pointers wrap past 7. count returns to 0.
- Simultaneous push/pop: count = 3, a push in READ coincides with a pop → count stays 3, head advances, new byte appended at the tail.
- Reset mid-operation: assert reset during READ with count = 5 → next cycle spi_read = 0, count = 0, empty = 1, state = IDLE. The in-flight byte is not written.
